// File: rtl/multicycle_control.sv
// Multicycle CPU control unit: FETCH/DECODE/EXEC/MEM/WB FSM with a memory
// wait-timeout watchdog that traps on a stalled bus access.
module multicycle_control #(
    parameter int OPCODE_W    = 4,
    parameter int FUNC_W      = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNC_W-1:0]   func,
    input  logic                alu_zero,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                ir_write,
    output logic                inst_fetch,
    output logic                alu_src,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                mem_read,
    output logic                mem_write,
    output logic                trap,
    output logic                bus_error,
    output logic [1:0]          pc_src,
    output logic [1:0]          alu_op,
    output logic [2:0]          state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        C_R    = 3'd0,
        C_LW   = 3'd1,
        C_SW   = 3'd2,
        C_ADDI = 3'd3,
        C_BEQ  = 3'd4,
        C_BNE  = 3'd5,
        C_JMP  = 3'd6,
        C_ILL  = 3'd7
    } class_e;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;

    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;

    localparam logic [7:0] WAIT_MAX = 8'(MEM_TIMEOUT);

    state_e     state_q, state_d;
    class_e     cls_q, cls_d;
    logic [1:0] rop_q, rop_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       bus_error_q, bus_error_d;

    class_e     dec_cls;
    logic [1:0] dec_rop;
    logic       timeout;
    logic       br_taken;

    // Instruction class and R-type ALU op decoded straight from the IR fields
    always_comb begin
        dec_cls = C_ILL;
        if (opcode <= OPCODE_W'(6)) begin
            case (opcode[2:0])
                3'd0:    dec_cls = C_R;
                3'd1:    dec_cls = C_LW;
                3'd2:    dec_cls = C_SW;
                3'd3:    dec_cls = C_ADDI;
                3'd4:    dec_cls = C_BEQ;
                3'd5:    dec_cls = C_BNE;
                3'd6:    dec_cls = C_JMP;
                default: dec_cls = C_ILL;
            endcase
        end
        dec_rop = ALU_ADD;
        if (func <= FUNC_W'(3)) begin
            dec_rop = func[1:0];
        end
    end

    // Next-state, latched-class, watchdog and control output logic
    always_comb begin
        state_d     = state_q;
        cls_d       = cls_q;
        rop_d       = rop_q;
        bus_error_d = bus_error_q;
        wait_cnt_d  = wait_cnt_q;

        pc_write    = 1'b0;
        ir_write    = 1'b0;
        inst_fetch  = 1'b0;
        alu_src     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        trap        = 1'b0;
        pc_src      = PC_INC;
        alu_op      = ALU_ADD;

        timeout  = (wait_cnt_q == WAIT_MAX);
        br_taken = alu_zero ^ (cls_q == C_BNE);

        case (state_q)
            S_FETCH: begin
                mem_read   = 1'b1;
                inst_fetch = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = PC_INC;
                    state_d  = S_DECODE;
                end else if (timeout) begin
                    state_d     = S_TRAP;
                    bus_error_d = 1'b1;
                end
            end

            // DECODE acts on the live decode; the latched copy serves later states
            S_DECODE: begin
                cls_d = dec_cls;
                rop_d = dec_rop;
                case (dec_cls)
                    C_JMP: begin
                        pc_write = 1'b1;
                        pc_src   = PC_JMP;
                        state_d  = S_FETCH;
                    end
                    C_ILL:   state_d = S_TRAP;
                    default: state_d = S_EXEC;
                endcase
            end

            S_EXEC: begin
                case (cls_q)
                    C_R: begin
                        alu_op  = rop_q;
                        state_d = S_WB;
                    end
                    C_ADDI: begin
                        alu_src = 1'b1;
                        alu_op  = ALU_ADD;
                        state_d = S_WB;
                    end
                    C_LW, C_SW: begin
                        alu_src = 1'b1;
                        alu_op  = ALU_ADD;
                        state_d = S_MEM;
                    end
                    C_BEQ, C_BNE: begin
                        alu_op = ALU_SUB;
                        if (br_taken) begin
                            pc_write = 1'b1;
                            pc_src   = PC_BR;
                        end
                        state_d = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end

            S_MEM: begin
                alu_src   = 1'b1;
                mem_read  = (cls_q == C_LW);
                mem_write = (cls_q == C_SW);
                if (mem_ready) begin
                    state_d = (cls_q == C_LW) ? S_WB : S_FETCH;
                end else if (timeout) begin
                    state_d     = S_TRAP;
                    bus_error_d = 1'b1;
                end
            end

            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (cls_q == C_LW);
                state_d    = S_FETCH;
            end

            S_TRAP: begin
                trap = 1'b1;
            end

            default: state_d = S_FETCH;
        endcase

        // Any state change restarts the wait count, so FETCH and MEM start at zero
        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end else if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready
                     && wait_cnt_q != WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    // State, latched decode, wait counter and bus error registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FETCH;
            cls_q       <= C_R;
            rop_q       <= ALU_ADD;
            wait_cnt_q  <= '0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cls_q       <= cls_d;
            rop_q       <= rop_d;
            wait_cnt_q  <= wait_cnt_d;
            bus_error_q <= bus_error_d;
        end
    end

    assign bus_error = bus_error_q;
    assign state     = state_q;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: OPCODE_W, 4, opcode field width; opcodes above 4'b0110 (zero-extended) are undefined.
REQ-002 Parameter: FUNC_W, 4, R-type function field width.
REQ-003 Parameter: MEM_TIMEOUT, 15, maximum consecutive wait cycles without mem_ready before bus error (range 1..255).
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 opcode  in  OPCODE_W  instruction opcode from IR, stable from DECODE until return to FETCH.
REQ-008 func  in  FUNC_W  R-type function field from IR.
REQ-009 alu_zero  in  1  ALU zero flag, valid in EXEC.
REQ-010 mem_ready  in  1  memory completion for the current access, sampled each cycle.
REQ-011 Outputs, each 1 bit: pc_write, ir_write, inst_fetch, alu_src, mem_to_reg, reg_write, mem_read, mem_write, trap, bus_error.
REQ-012 pc_src  out  2  00=PC+2, 01=branch target, 10=jump target.
REQ-013 alu_op  out  2  00=add, 01=sub, 10=sll, 11=and.
REQ-014 state  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.

Function
REQ-015 States: FETCH, DECODE, EXEC, MEM, WB, TRAP; registered state; control outputs combinational from state, latched class and inputs.
REQ-016 Decoded class (R, LW, SW, ADDI, BEQ, BNE, JMP, ILL) and R-type alu_op latched in DECODE and held until the next DECODE.
REQ-017 Opcode map: 0=R, 1=LW, 2=SW, 3=ADDI, 4=BEQ, 5=BNE, 6=JMP, all others ILL.
REQ-018 R-type func map: 0=add, 1=sub, 2=sll, 3=and, others=add.
REQ-019 Outputs not asserted by a rule below are 0.
REQ-020 FETCH: mem_read=1, inst_fetch=1; on mem_ready=1: ir_write=1, pc_write=1, pc_src=00, next DECODE; otherwise stay.
REQ-021 DECODE: JMP -> pc_write=1, pc_src=10, next FETCH; ILL -> next TRAP; all other classes -> next EXEC.
REQ-022 EXEC, R: alu_op=latched op, next WB.
REQ-023 EXEC, ADDI: alu_src=1, alu_op=00, next WB.
REQ-024 EXEC, LW/SW: alu_src=1, alu_op=00, next MEM.
REQ-025 EXEC, BEQ/BNE: alu_op=01; pc_write=1, pc_src=01 iff (alu_zero XOR class==BNE); next FETCH.
REQ-026 MEM: LW drives mem_read=1, SW drives mem_write=1, both with alu_src=1; on mem_ready=1, LW -> WB, SW -> FETCH; otherwise stay.
REQ-027 WB: reg_write=1; mem_to_reg=1 for LW only; next FETCH.
REQ-028 Zero-wait cycle counts: JMP 2, BEQ/BNE 3, R/ADDI/SW 4, LW 5.
REQ-029 Wait counter: cleared on entry to FETCH or MEM; increments each cycle in FETCH or MEM with mem_ready=0; saturates at MEM_TIMEOUT.
REQ-030 Bus error: in FETCH or MEM with mem_ready=0 and counter==MEM_TIMEOUT -> next TRAP, bus_error set.
REQ-031 mem_ready=1 in the timeout cycle wins: the access completes and no trap occurs.
REQ-032 TRAP: trap=1, all memory, register and PC controls 0; remains until rst.
REQ-033 bus_error is sticky in TRAP and stays 0 for an ILL trap.

Reset
REQ-034 While rst=1 at a clock edge: state<=FETCH, wait counter<=0, class<=R with alu_op 00, bus_error<=0.
REQ-035 rst overrides every transition, including in TRAP, in MEM mid-wait and in a mem_ready cycle.
REQ-036 In the first cycle after reset: state=0, mem_read=1, inst_fetch=1, all other outputs 0.

Verification
REQ-037 Reset, then opcode=0, func=1, mem_ready=1 -> state sequence 0,1,2,4,0; alu_op=01 in EXEC; reg_write=1 only in WB.
REQ-038 opcode=1 with mem_ready low for 3 cycles in MEM -> mem_read held 4 cycles; WB has mem_to_reg=1, reg_write=1; total 8 cycles.
REQ-039 opcode=5 with alu_zero=0 -> pc_write=1, pc_src=01 in EXEC; repeat with alu_zero=1 -> pc_write=0; both return to FETCH after 3 cycles.
REQ-040 opcode=4'b1001 -> TRAP (state=7) after DECODE; trap=1, bus_error=0; holds 20 cycles; rst -> state=0.
REQ-041 Timeout, mem_ready held 0 in FETCH with MEM_TIMEOUT=15:
- state=7 and bus_error=1 after 16 FETCH cycles.
- Rerun with mem_ready=1 in cycle 16: normal DECODE, no trap.
REQ-042 opcode=6 -> pc_write=1, pc_src=10 in DECODE; next state FETCH; no reg_write or mem_write at any point.
